// File: rtl/fir_decimator_pkg.sv
// fir_decimator_pkg: shared width helpers and constants for the fir_decimator slice
package fir_decimator_pkg;

    localparam int LW_DEF = 3;
    localparam int PH_W = 2**LW_DEF - 1;

    function automatic int acc_width(input int m, input int lw);
        return m + 2**lw - 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fir_decimator_fifo.sv
// fir_decimator_fifo: synchronous FIFO with registered storage; a full FIFO accepts a push only alongside a pop
module fir_decimator_fifo
    import fir_decimator_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [M-1:0]                  din,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [M-1:0]                  dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [M-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage, power-of-two pointers that wrap naturally, and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// fir_decimator: decimate by 2^ratio_log2 into an output FIFO; define FIR_DECIMATOR_AVG_EN for boxcar averaging instead of picking
module fir_decimator
    import fir_decimator_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 4,
    parameter int LW    = LW_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [M-1:0]                  in_data,
    input  logic [LW-1:0]                 ratio_log2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [M-1:0]                  out_data,
    output logic [cnt_width(DEPTH)-1:0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = (LW == LW_DEF) ? PH_W : 2**LW - 1;

    logic [PW-1:0] phase;
    logic [LW-1:0] k_q;
    logic [LW-1:0] k;
    logic [PW:0]   r_len;
    logic          first;
    logic          last;
    logic          push;
    logic [M-1:0]  push_data;
    logic          full;
    logic          empty;

    // A new frame uses the live ratio; the rest of the frame uses the latched one
    assign first = phase == '0;
    assign k     = first ? ratio_log2 : k_q;
    assign r_len = (PW+1)'(1) << k;
    assign last  = phase == PW'(r_len - 1'b1);

    // Phase advances per accepted sample and wraps at R-1; ratio latched at frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= '0;
            k_q   <= '0;
        end else if (in_valid) begin
            phase <= last ? '0 : phase + 1'b1;
            if (first) k_q <= ratio_log2;
        end
    end

`ifdef FIR_DECIMATOR_AVG_EN
    localparam int AW = acc_width(M, LW);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    assign acc_sum   = first ? AW'(in_data) : acc + AW'(in_data);
    assign push      = in_valid && last;
    assign push_data = M'(acc_sum >> k);

    // Frame sum; the first sample loads rather than adding to the previous frame
    always_ff @(posedge clk) begin
        if (reset) acc <= '0;
        else if (in_valid) acc <= last ? '0 : acc_sum;
    end
`else
    assign push      = in_valid && first;
    assign push_data = in_data;
`endif

    // Sticky drop flag: a push into a full FIFO that is not draining this cycle
    always_ff @(posedge clk) begin
        if (reset) overflow <= 1'b0;
        else if (push && full && !out_ready) overflow <= 1'b1;
    end

    assign out_valid = !empty;

    fir_decimator_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (out_ready),
        .full  (full),
        .empty (empty),
        .count (fifo_count),
        .dout  (out_data)
    );

endmodule

// File: tb/tb_fir_decimator.sv
// tb_fir_decimator: table-driven directed vectors plus hand sequences for overflow and mid-frame reset
module tb_fir_decimator;

    localparam int M     = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FIR_DECIMATOR_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    typedef struct {
        int rst, vld, din, k, rdy;
        int ev, ed, ec, eo;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [M-1:0]  in_data;
    logic [LW-1:0] ratio_log2;
    logic          out_valid;
    logic          out_ready;
    logic [M-1:0]  out_data;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    fir_decimator #(.M(M), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .ratio_log2 (ratio_log2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic void add(int r, int vl, int d, int k, int rd, int ev, int ed, int ec, int eo);
        tbl.push_back('{r, vl, d, k, rd, ev, ed, ec, eo});
    endfunction

    task automatic step(int r, int vl, int d, int k, int rd);
        reset      = 1'(r);
        in_valid   = 1'(vl);
        in_data    = M'(d);
        ratio_log2 = LW'(k);
        out_ready  = 1'(rd);
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int ev, int ed, int ec, int eo);
        n_vec++;
        if (int'(out_valid) != ev || int'(fifo_count) != ec || int'(overflow) != eo ||
            (ev != 0 && int'(out_data) != ed)) begin
            n_err++;
            $display("FAIL %s: got valid=%0d data=%0h count=%0d ovf=%0d, want valid=%0d data=%0h count=%0d ovf=%0d",
                     name, out_valid, out_data, fifo_count, overflow, ev, ed, ec, eo);
        end
    endtask

    initial begin
        int a2[6];
        int avg2[3];
        int heads[3];
        reset = 1'b1; in_valid = 1'b0; in_data = '0; ratio_log2 = '0; out_ready = 1'b0;
        a2   = '{10, 20, 7, 8, 255, 255};
        avg2 = '{15, 7, 255};

        // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // R=4 over 0..15: pick emits phase-0 samples, average emits frame means
        for (int i = 0; i < 16; i++) begin
            int pv;
            pv = AVG ? ((i % 4 == 3) ? 1 : 0) : ((i % 4 == 0) ? 1 : 0);
            add(0, 1, i, 2, 1, pv, AVG ? 4 * (i / 4) + 1 : i, pv, 0);
        end
        add(0, 0, 0, 2, 1, 0, 0, 0, 0);
        // R=2 over 10,20,7,8,255,255
        for (int j = 0; j < 6; j++) begin
            int pv;
            pv = AVG ? ((j % 2 == 1) ? 1 : 0) : ((j % 2 == 0) ? 1 : 0);
            add(0, 1, a2[j], 1, 1, pv, AVG ? avg2[j / 2] : a2[j], pv, 0);
        end
        add(0, 0, 0, 1, 1, 0, 0, 0, 0);
        // ratio drops to 0 mid-frame: rest of frame still uses R=4
        add(0, 1, 'h20, 2, 1, AVG ? 0 : 1, 'h20, AVG ? 0 : 1, 0);
        add(0, 1, 'h21, 2, 1, 0, 0, 0, 0);
        add(0, 1, 'h22, 0, 1, 0, 0, 0, 0);
        add(0, 1, 'h23, 0, 1, AVG ? 1 : 0, 'h21, AVG ? 1 : 0, 0);
        add(0, 1, 'h24, 0, 1, 1, 'h24, 1, 0);
        add(0, 1, 'h25, 0, 1, 1, 'h25, 1, 0);
        add(0, 1, 'h26, 0, 1, 1, 'h26, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].din, tbl[i].k, tbl[i].rdy);
            check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].eo);
        end

        // R=1 with consumer stalled: fill to DEPTH, then drops set overflow
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, i, 0, 0);
            check($sformatf("ovf_fill%0d", i), 1, 1, (i < 4) ? i : 4, (i > 4) ? 1 : 0);
        end
        // full FIFO with push and pop together: head 1 leaves, 9 enters
        step(0, 1, 9, 0, 1);
        check("full_pushpop", 1, 2, 4, 1);
        heads = '{3, 4, 9};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            check($sformatf("drain%0d", i), 1, heads[i], 2 - i + 1, 1);
        end
        step(0, 0, 0, 0, 1);
        check("drain_empty", 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("pop_when_empty", 0, 0, 0, 1);

        // queue entries and leave the frame at phase 2, then reset
        for (int j = 0; j < 6; j++) begin
            int ec;
            ec = AVG ? ((j >= 3) ? 1 : 0) : ((j >= 4) ? 2 : 1);
            step(0, 1, 'h10 * (j + 1), 2, 0);
            check($sformatf("prefill%0d", j), (ec != 0) ? 1 : 0, AVG ? 'h28 : 'h10, ec, 1);
        end
        step(1, 0, 0, 2, 0);
        check("reset_mid", 0, 0, 0, 0);
        // phase restarts at 0: pick emits A5 at once, average emits after four samples
        for (int j = 0; j < 4; j++) begin
            int ec;
            int d;
            d  = (j == 0) ? 'hA5 : j;
            ec = AVG ? ((j == 3) ? 1 : 0) : 1;
            step(0, 1, d, 2, 0);
            check($sformatf("post_reset%0d", j), ec, AVG ? 'h2A : 'hA5, ec, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
